// File: rtl/spi_con_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_con controller among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_con_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            ack_out,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id_out,
  output logic                          resp_err_out,
  output logic                          busy_out,
  output logic [DATA_WIDTH-1:0]         spi_data_out,
  output logic                          spi_trigger_out,
  input  logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_valid_in
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         last_grant_q, last_grant_d;
  logic [IDW-1:0]         resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0]  spi_data_q, spi_data_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   resp_err_q, resp_err_d;
  logic                   trig_q, trig_d;
  logic                   busy_q, busy_d;

  logic                   rr_found_s;
  logic [IDW-1:0]         rr_idx_s;
  logic [DATA_WIDTH-1:0]  rr_data_s;
  logic                   timeout_hit_s;

  // Pick the first requesting index after last_grant, wrapping, together with its data slice.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    rr_data_s  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rr_found_s && req_in[i] && (((int'(last_grant_q) + off) % NUM_REQ) == i)) begin
          rr_found_s = 1'b1;
          rr_idx_s   = IDW'(i);
          rr_data_s  = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog counts WAIT cycles; cleared while issuing so it starts at zero on WAIT entry.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_cnt_d = wd_cnt_q + TOW'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // The count equals the number of completed WAIT cycles, so expiry lands on WAIT cycle TIMEOUT_CYCLES.
  assign timeout_hit_s = (state_q == ST_WAIT) && (wd_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;

  // TIMEOUT_CYCLES only matters to the watchdog build; keep it referenced here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  // Next-state and registered-output logic; outputs are loaded on the transition into their cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    spi_data_d   = spi_data_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    ack_d        = '0;
    trig_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_found_s) begin
          grant_d      = rr_idx_s;
          last_grant_d = rr_idx_s;
          spi_data_d   = rr_data_s;
          trig_d       = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Valid data beats a simultaneous watchdog expiry.
        if (spi_valid_in) begin
          resp_data_d = spi_data_in;
          resp_err_d  = 1'b0;
          resp_id_d   = grant_q;
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (grant_q == IDW'(i));
          end
          state_d = ST_RESP;
        end else if (timeout_hit_s) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          resp_id_d   = grant_q;
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (grant_q == IDW'(i));
          end
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      spi_data_q   <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      ack_q        <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      spi_data_q   <= spi_data_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
      ack_q        <= ack_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_out         = ack_q;
  assign resp_data_out   = resp_data_q;
  assign resp_id_out     = resp_id_q;
  assign resp_err_out    = resp_err_q;
  assign busy_out        = busy_q;
  assign spi_data_out    = spi_data_q;
  assign spi_trigger_out = trig_q;

endmodule

// File: doc/spi_con_arbiter.md
Name: spi_con_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one spi_con controller among NUM_REQ on-chip requesters (e.g. vote encryptor, tally readback, debug switches).
- Accepts one word-transfer request at a time, drives spi_con data_in/trigger_in, waits for data_valid_out, and returns the received word to the granted requester.
- Sits between the requesters and the spi_con instance in top_level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, SPI word width; must match the spi_con DATA_WIDTH.
- TIMEOUT_CYCLES, 4096, WAIT-state watchdog limit in clk_in cycles (used only with the optional feature).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- req_in  input  NUM_REQ  per-requester request level; held high until the matching ack_out pulse.
- req_data_in  input  NUM_REQ*DATA_WIDTH  flattened transmit words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack_out  output  NUM_REQ  one-cycle done pulse to the granted requester.
- resp_data_out  output  DATA_WIDTH  received word; valid while any ack_out bit is high.
- resp_id_out  output  $clog2(NUM_REQ)  index of the requester being acknowledged.
- resp_err_out  output  1  timeout flag; qualified by ack_out.
- busy_out  output  1  high in any state other than IDLE.
- spi_data_out  output  DATA_WIDTH  drives spi_con data_in.
- spi_trigger_out  output  1  drives spi_con trigger_in; single-cycle pulse.
- spi_data_in  input  DATA_WIDTH  from spi_con data_out.
- spi_valid_in  input  1  from spi_con data_valid_out.

Behaviour:
Reset:
- Every output is 0. State = IDLE. Captured grant and data = 0. last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-transfer aborts immediately. No ack is issued. An spi_valid_in that arrives after reset is ignored because the block is in IDLE.

FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: if req_in != 0, select the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Register grant index, capture that requester's req_data_in slice into spi_data_out, update last_grant, go to ISSUE. If req_in == 0, stay in IDLE.
- ISSUE: spi_trigger_out = 1 for exactly this cycle; go to WAIT.
- WAIT: hold spi_data_out stable. When spi_valid_in = 1, register spi_data_in into resp_data_out and go to RESP.
- RESP: ack_out[grant] = 1, resp_id_out = grant, resp_err_out as described in Optional Feature; return to IDLE.

Timing:
- Minimum latency from request sampled in IDLE to ack_out is 3 cycles plus the spi_con transfer time. spi_valid_in sampled in cycle t gives ack_out in cycle t+1.
- Back-to-back: the cycle after RESP is IDLE, and arbitration happens in that cycle. Throughput is one transfer per (spi_con time + 3) cycles.

Request and response rules:
- A requester still holding req_in in the cycle after its ack is treated as a new request. Round-robin order means every other pending requester is served first.
- req_in dropped before grant: the request is withdrawn with no side effects.
- req_in dropped after grant: the transfer still completes and the ack pulse is still issued.
- req_data_in is sampled only at grant. Later changes are ignored.
- spi_valid_in outside WAIT is ignored.
- resp_data_out and resp_id_out hold their last values between acks; they are meaningful only while ack_out is high.

Optional Feature:
Macro: SPI_ARB_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no spi_valid_in, go to RESP with resp_data_out = 0 and resp_err_out = 1.
- spi_valid_in in the same cycle as expiry wins: normal data is returned and resp_err_out = 0.
- Not defined: no counter exists, resp_err_out is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request: after reset, req_in=4'b0001 with data 8'hA5; spi_valid_in returns 8'h3C 50 cycles after the trigger. Required: one spi_trigger_out pulse with spi_data_out=8'hA5, then ack_out=4'b0001, resp_data_out=8'h3C, resp_id_out=0, resp_err_out=0.
- Round-robin: req_in=4'b1111 held continuously. Required: grant order 0,1,2,3,0, with exactly one ack per transfer and no requester granted twice before all others are served.
- Reset mid-transfer: assert rst_in during WAIT, then pulse spi_valid_in after release. Required: no ack_out, busy_out=0, all outputs 0, and the next request goes to requester 0.
- Withdrawn request: raise req_in[2] while busy serving 1, then drop it before the transfer ends. Required: requester 2 is never granted, and the block returns to IDLE with busy_out=0.
- Timeout (SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): grant requester 3 and never assert spi_valid_in. Required: ack_out[3] exactly 16 WAIT cycles after entry, with resp_err_out=1 and resp_data_out=0. Without the macro: no ack after 10000 cycles and busy_out stays 1.
- Data stability: change req_data_in[1] on every cycle during WAIT. Required: spi_data_out holds the grant-time value throughout the transfer.
